ddr3_cmd_decoder: RTL and testbench

Passive responder-side decoder for the DDR3 command bus driven by ddr3_controller. It samples CKE/CS_N/RAS_N/CAS_N/WE_N/BA/ADDR on each rising edge of the memory clock and emits a registered, decoded command stream. It shadows the mode registers, tracks per-bank open rows, and flags protocol and timing violations. It serves as the command front end of a synthesizable DRAM stand-in and as a checker in controller benches.

---
 rtl/ddr3_cmd_decoder.sv | 168 ++++++++++++++++
 tb/tb_ddr3_cmd_decoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_cmd_decoder.sv
// rtl/ddr3_cmd_decoder.sv - DDR3 command bus decoder with mode-register shadows, bank tracking and timing checks
module ddr3_cmd_decoder #(
  parameter int BA_BITS   = 3,
  parameter int ADDR_BITS = 14,
  parameter int TRCD      = 6,
  parameter int TRP       = 6,
  parameter int TMRD      = 4,
  parameter int TRFC      = 44
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cke,
  input  logic                    cs_n,
  input  logic                    ras_n,
  input  logic                    cas_n,
  input  logic                    we_n,
  input  logic [BA_BITS-1:0]      ba,
  input  logic [ADDR_BITS-1:0]    addr,
  output logic                    cmd_valid,
  output logic [2:0]              cmd_code,
  output logic [BA_BITS-1:0]      cmd_ba,
  output logic [ADDR_BITS-1:0]    cmd_addr,
  output logic                    cmd_ap,
  output logic [ADDR_BITS-1:0]    mr0,
  output logic [ADDR_BITS-1:0]    mr1,
  output logic [ADDR_BITS-1:0]    mr2,
  output logic [ADDR_BITS-1:0]    mr3,
  output logic [(1<<BA_BITS)-1:0] bank_open,
  output logic                    err_valid,
  output logic [2:0]              err_code,
  output logic [7:0]              err_count
);

  localparam int NB = 1 << BA_BITS;
  localparam int CW = 8;

  localparam logic [2:0] C_MRS = 3'd0;
  localparam logic [2:0] C_REF = 3'd1;
  localparam logic [2:0] C_PRE = 3'd2;
  localparam logic [2:0] C_ACT = 3'd3;
  localparam logic [2:0] C_WR  = 3'd4;
  localparam logic [2:0] C_RD  = 3'd5;

  localparam logic [2:0] E_ACT_OPEN  = 3'd1;
  localparam logic [2:0] E_RW_CLOSED = 3'd2;
  localparam logic [2:0] E_TRCD      = 3'd3;
  localparam logic [2:0] E_TRP       = 3'd4;
  localparam logic [2:0] E_TMRD      = 3'd5;
  localparam logic [2:0] E_REF_OPEN  = 3'd6;
  localparam logic [2:0] E_TRFC      = 3'd7;

  logic [2:0]    op;
  logic          live;
  logic          is_rw;
  logic          err_hit;
  logic [2:0]    err_sel;
  logic [CW-1:0] trcd_q [NB];
  logic [CW-1:0] trp_q  [NB];
  logic [CW-1:0] tmrd_q;
  logic [CW-1:0] trfc_q;

  // The strobe triple maps directly onto the command code; 3'b111 is NOP.
  assign op    = {ras_n, cas_n, we_n};
  assign live  = cke && !cs_n && (op != 3'b111);
  assign is_rw = (op == C_RD) || (op == C_WR);

  always_comb begin
    err_hit = 1'b0;
    err_sel = 3'd0;
    if (live) begin
      if (tmrd_q != '0) begin
        err_hit = 1'b1; err_sel = E_TMRD;
      end else if (trfc_q != '0) begin
        err_hit = 1'b1; err_sel = E_TRFC;
      end else if (op == C_ACT && trp_q[ba] != '0) begin
        err_hit = 1'b1; err_sel = E_TRP;
      end else if (op == C_ACT && bank_open[ba]) begin
        err_hit = 1'b1; err_sel = E_ACT_OPEN;
      end else if (is_rw && !bank_open[ba]) begin
        err_hit = 1'b1; err_sel = E_RW_CLOSED;
      end else if (is_rw && trcd_q[ba] != '0) begin
        err_hit = 1'b1; err_sel = E_TRCD;
      end else if (op == C_REF && |bank_open) begin
        err_hit = 1'b1; err_sel = E_REF_OPEN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_ba    <= '0;
      cmd_addr  <= '0;
      cmd_ap    <= 1'b0;
      mr0       <= '0;
      mr1       <= '0;
      mr2       <= '0;
      mr3       <= '0;
      bank_open <= '0;
      err_valid <= 1'b0;
      err_code  <= '0;
      err_count <= '0;
      tmrd_q    <= '0;
      trfc_q    <= '0;
      for (int i = 0; i < NB; i++) begin
        trcd_q[i] <= '0;
        trp_q[i]  <= '0;
      end
    end else begin
      cmd_valid <= live;
      cmd_code  <= live ? op : 3'd0;
      cmd_ba    <= live ? ba : '0;
      cmd_addr  <= live ? addr : '0;
      cmd_ap    <= live && (is_rw || op == C_PRE) && addr[10];
      err_valid <= err_hit;
      err_code  <= err_sel;
      if (err_hit && err_count != 8'hFF)
        err_count <= err_count + 8'd1;

      // Free-running saturating decrements; command loads below take precedence.
      tmrd_q <= (tmrd_q != '0) ? tmrd_q - 1'b1 : tmrd_q;
      trfc_q <= (trfc_q != '0) ? trfc_q - 1'b1 : trfc_q;
      for (int i = 0; i < NB; i++) begin
        trcd_q[i] <= (trcd_q[i] != '0) ? trcd_q[i] - 1'b1 : trcd_q[i];
        trp_q[i]  <= (trp_q[i]  != '0) ? trp_q[i]  - 1'b1 : trp_q[i];
      end

      if (live) begin
        case (op)
          C_MRS: begin
            tmrd_q <= CW'(TMRD - 1);
            if (!ba[2]) begin
              case (ba[1:0])
                2'd0:    mr0 <= addr;
                2'd1:    mr1 <= addr;
                2'd2:    mr2 <= addr;
                default: mr3 <= addr;
              endcase
            end
          end
          C_REF: trfc_q <= CW'(TRFC - 1);
          C_PRE: begin
            if (addr[10]) begin
              bank_open <= '0;
              for (int i = 0; i < NB; i++) trp_q[i] <= CW'(TRP - 1);
            end else begin
              bank_open[ba] <= 1'b0;
              trp_q[ba]     <= CW'(TRP - 1);
            end
          end
          C_ACT: begin
            bank_open[ba] <= 1'b1;
            trcd_q[ba]    <= CW'(TRCD - 1);
          end
          C_WR, C_RD: begin
            if (addr[10]) begin
              bank_open[ba] <= 1'b0;
              trp_q[ba]     <= CW'(TRP - 1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_decoder.sv
// tb/tb_ddr3_cmd_decoder.sv - scoreboard bench for ddr3_cmd_decoder using directed vectors
module tb_ddr3_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cke = 1'b0;
  logic        cs_n = 1'b1;
  logic        ras_n = 1'b1;
  logic        cas_n = 1'b1;
  logic        we_n = 1'b1;
  logic [2:0]  ba = '0;
  logic [13:0] addr = '0;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [2:0]  cmd_ba;
  logic [13:0] cmd_addr;
  logic        cmd_ap;
  logic [13:0] mr0, mr1, mr2, mr3;
  logic [7:0]  bank_open;
  logic        err_valid;
  logic [2:0]  err_code;
  logic [7:0]  err_count;

  typedef struct packed {
    logic [2:0]  code;
    logic [2:0]  ba;
    logic [13:0] addr;
    logic        ap;
    logic [2:0]  err;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail = 0;

  ddr3_cmd_decoder dut (
    .clk(clk), .rst_n(rst_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ba(cmd_ba),
    .cmd_addr(cmd_addr), .cmd_ap(cmd_ap), .mr0(mr0), .mr1(mr1), .mr2(mr2),
    .mr3(mr3), .bank_open(bank_open), .err_valid(err_valid),
    .err_code(err_code), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [2:0] code, input logic [2:0] b,
                       input logic [13:0] a, input logic [2:0] e);
    exp_t x;
    @(negedge clk);
    cke = 1'b1; cs_n = 1'b0; {ras_n, cas_n, we_n} = code; ba = b; addr = a;
    x.code = code; x.ba = b; x.addr = a; x.err = e;
    x.ap   = (code == 3'd2 || code == 3'd4 || code == 3'd5) && a[10];
    if (rst_n) exp_q.push_back(x);
  endtask

  task automatic nop(input int n);
    repeat (n) begin
      @(negedge clk);
      cke = 1'b1; cs_n = 1'b1;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: pops one expectation per presented command.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (cmd_valid) begin
          if (exp_q.size() == 0) begin
            chk("spurious_cmd_valid", 32'(cmd_valid), 32'd0);
          end else begin
            x = exp_q.pop_front();
            chk("cmd_code", 32'(cmd_code), 32'(x.code));
            chk("cmd_ba", 32'(cmd_ba), 32'(x.ba));
            chk("cmd_addr", 32'(cmd_addr), 32'(x.addr));
            chk("cmd_ap", 32'(cmd_ap), 32'(x.ap));
            chk("err_valid", 32'(err_valid), 32'(x.err != 3'd0));
            if (x.err != 3'd0) chk("err_code", 32'(err_code), 32'(x.err));
          end
        end else if (err_valid) begin
          chk("err_without_cmd", 32'(err_valid), 32'd0);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  localparam logic [2:0] MRS = 3'd0, REF = 3'd1, PRE = 3'd2, ACT = 3'd3,
                         WR = 3'd4, RD = 3'd5, ZQ = 3'd6;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_bank_open", 32'(bank_open), 32'd0);
    rst_n = 1'b1;

    // Mode register loads with a legal tMRD gap
    issue(MRS, 3'd0, 14'h0D70, 3'd0);
    nop(3);
    issue(MRS, 3'd1, 14'h0044, 3'd0);
    settle();
    chk("mr0_load", 32'(mr0), 32'h0D70);
    chk("mr1_load", 32'(mr1), 32'h0044);
    chk("err_count_clean", 32'(err_count), 32'd0);
    nop(5);

    // tMRD violation still opens the bank
    issue(MRS, 3'd2, 14'h0008, 3'd0);
    nop(1);
    issue(ACT, 3'd4, 14'h0123, 3'd5);
    settle();
    chk("tmrd_bank_open4", 32'(bank_open[4]), 32'd1);
    chk("tmrd_err_count", 32'(err_count), 32'd1);
    chk("mr2_load", 32'(mr2), 32'h0008);
    nop(5);

    // tRCD boundary on bank 3
    issue(ACT, 3'd3, 14'h1ABC, 3'd0);
    nop(4);
    issue(RD, 3'd3, 14'h0012, 3'd3);
    issue(PRE, 3'd3, 14'h0000, 3'd0);
    nop(5);
    issue(ACT, 3'd3, 14'h1ABC, 3'd0);
    nop(5);
    issue(RD, 3'd3, 14'h0034, 3'd0);
    settle();
    chk("rd_bank_open3", 32'(bank_open[3]), 32'd1);
    issue(WR, 3'd3, 14'h0056, 3'd0);

    // Auto-precharge and tRP boundary on bank 2
    issue(ACT, 3'd2, 14'h0200, 3'd0);
    nop(5);
    issue(RD, 3'd2, 14'h0410, 3'd0);
    settle();
    chk("rdap_bank_open2", 32'(bank_open[2]), 32'd0);
    nop(4);
    issue(ACT, 3'd2, 14'h0201, 3'd4);
    nop(5);
    issue(RD, 3'd2, 14'h0400, 3'd0);
    nop(5);
    issue(ACT, 3'd2, 14'h0202, 3'd0);

    // Precharge-all, refresh rules, tRFC boundary
    issue(PRE, 3'd0, 14'h0400, 3'd0);
    settle();
    chk("pre_all_closed", 32'(bank_open), 32'd0);
    nop(5);
    issue(ACT, 3'd0, 14'h0010, 3'd0);
    issue(ACT, 3'd5, 14'h0050, 3'd0);
    settle();
    chk("banks_0_5_open", 32'(bank_open), 32'h21);
    issue(PRE, 3'd0, 14'h0400, 3'd0);
    nop(5);
    issue(REF, 3'd0, 14'h0000, 3'd0);
    nop(42);
    issue(ACT, 3'd1, 14'h0011, 3'd7);
    issue(REF, 3'd0, 14'h0000, 3'd6);
    nop(44);
    settle();
    chk("err_count_5", 32'(err_count), 32'd5);

    // ZQ decode, MRS with ba[2]=1, CKE-low masking
    issue(ZQ, 3'd0, 14'h0400, 3'd0);
    issue(MRS, 3'd4, 14'h1FFF, 3'd0);
    @(negedge clk);
    cke = 1'b0; cs_n = 1'b0; {ras_n, cas_n, we_n} = RD; ba = 3'd7;
    settle();
    chk("mrs_ba4_mr0", 32'(mr0), 32'h0D70);
    chk("mrs_ba4_mr1", 32'(mr1), 32'h0044);
    nop(3);

    // Saturating error counter
    for (int i = 0; i < 249; i++) issue(RD, 3'd7, 14'h0001, 3'd2);
    settle();
    chk("err_count_254", 32'(err_count), 32'd254);
    for (int i = 0; i < 51; i++) issue(RD, 3'd7, 14'h0001, 3'd2);
    settle();
    chk("err_count_sat", 32'(err_count), 32'd255);

    // Asynchronous reset mid-burst
    issue(RD, 3'd7, 14'h0002, 3'd2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("async_err_valid", 32'(err_valid), 32'd0);
    chk("async_err_count", 32'(err_count), 32'd0);
    chk("async_bank_open", 32'(bank_open), 32'd0);
    chk("async_mr0", 32'(mr0), 32'd0);
    chk("async_cmd_addr", 32'(cmd_addr), 32'd0);
    issue(RD, 3'd7, 14'h0003, 3'd0);
    @(negedge clk);
    rst_n = 1'b1; cs_n = 1'b1;
    nop(2);
    issue(ACT, 3'd6, 14'h0066, 3'd0);
    settle();
    chk("post_rst_bank_open", 32'(bank_open), 32'h40);
    chk("post_rst_err_count", 32'(err_count), 32'd0);
    nop(2);
    settle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
